// File: rtl/pipe_mux_skid_if.sv
// Handshake and data bundle for pipe_mux_skid: upstream beat, downstream slot, flush.
// sel_err exists only when PMS_SEL_ERR_EN is defined.
interface pipe_mux_skid_if #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int SEL_W = 2
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [N*W-1:0]   din;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     dout;
    logic [SEL_W-1:0] out_sel;
`ifdef PMS_SEL_ERR_EN
    logic             sel_err;

    modport slave (
        input  flush, in_valid, sel, din, out_ready,
        output in_ready, out_valid, dout, out_sel, sel_err
    );
    modport master (
        output flush, in_valid, sel, din, out_ready,
        input  in_ready, out_valid, dout, out_sel, sel_err
    );
`else
    modport slave (
        input  flush, in_valid, sel, din, out_ready,
        output in_ready, out_valid, dout, out_sel
    );
    modport master (
        output flush, in_valid, sel, din, out_ready,
        input  in_ready, out_valid, dout, out_sel
    );
`endif
endinterface

// File: rtl/pipe_mux_skid.sv
// N-way W-bit channel select registered into a valid/ready slot with a 2-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining PMS_SEL_ERR_EN.
module pipe_mux_skid #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    pipe_mux_skid_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     mainData_q, mainData_d;
    logic [W-1:0]     skidData_q, skidData_d;
    logic [SEL_W-1:0] mainSel_q, mainSel_d;
    logic [SEL_W-1:0] skidSel_q, skidSel_d;
    logic             inReady_q, inReady_d;
    logic [W-1:0]     selData;
    logic             accept;

    // Selects with no matching channel fall through to the all-zero default.
    always_comb begin
        selData = '0;
        for (int k = 0; k < N; k++) begin
            if (32'(bus.sel) == 32'(k)) begin
                selData = bus.din[k*W +: W];
            end
        end
    end

    assign accept = bus.in_valid && inReady_q;

    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainSel_d  = mainSel_q;
        skidData_d = skidData_q;
        skidSel_d  = skidSel_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        mainData_d = selData;
                        mainSel_d  = bus.sel;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (accept && bus.out_ready) begin
                        mainData_d = selData;
                        mainSel_d  = bus.sel;
                    end else if (accept) begin
                        skidData_d = selData;
                        skidSel_d  = bus.sel;
                        state_d    = TWO;
                    end else if (bus.out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (bus.out_ready) begin
                        mainData_d = skidData_q;
                        mainSel_d  = skidSel_q;
                        state_d    = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        inReady_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainSel_q  <= '0;
            skidData_q <= '0;
            skidSel_q  <= '0;
            inReady_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainSel_q  <= mainSel_d;
            skidData_q <= skidData_d;
            skidSel_q  <= skidSel_d;
            inReady_q  <= inReady_d;
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.dout      = mainData_q;
    assign bus.out_sel   = mainSel_q;

`ifdef PMS_SEL_ERR_EN
    logic selErr_q;
    logic selErr_d;

    // Sticky: any accepted out-of-range select latches the flag until reset.
    always_comb begin
        selErr_d = selErr_q;
        if (accept && (32'(bus.sel) >= 32'(N))) begin
            selErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            selErr_q <= 1'b0;
        end else begin
            selErr_q <= selErr_d;
        end
    end

    assign bus.sel_err = selErr_q;
`else
    // Without the flag, out-of-range selects just produce zero data.
`endif
endmodule
